// File: rtl/ym2610_cmd_arbiter_if.sv
// Requester-side command bus and controller-side Wishbone write port of the YM2610 arbiter.
// master: arbiter view; slave: requesters plus controller view.
interface ym2610_cmd_arbiter_if #(
  parameter int unsigned NUM_REQ = 2
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [3*NUM_REQ-1:0] req_addr;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic [2:0]           wb_addr;
  logic [7:0]           wb_wdata;
  logic                 wb_we;
  logic                 wb_cyc;
  logic                 wb_ack;

  modport master (
    input  req_valid, req_addr, req_data, wb_ack,
    output req_ready, wb_addr, wb_wdata, wb_we, wb_cyc
  );

  modport slave (
    output req_valid, req_addr, req_data, wb_ack,
    input  req_ready, wb_addr, wb_wdata, wb_we, wb_cyc
  );
endinterface

// File: rtl/ym2610_cmd_arbiter.sv
// Round-robin arbiter for the YM2610 command port with address/data pair locking.
// Optional YM_ARB_LOCK_TIMEOUT_EN: force-release an idle lock after LOCK_TIMEOUT cycles.
module ym2610_cmd_arbiter #(
  parameter int unsigned  NUM_REQ      = 2,
  parameter int unsigned  LOCK_TIMEOUT = 1024,
  localparam int unsigned GW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  ym2610_cmd_arbiter_if.master  bus,
  output logic [GW-1:0]         grant_id,
  output logic                  locked,
  output logic                  lock_timeout
);

  if (NUM_REQ < 1 || NUM_REQ > 8 || LOCK_TIMEOUT < 1) begin : g_param_check
    $error("ym2610_cmd_arbiter: unsupported NUM_REQ or LOCK_TIMEOUT");
  end

  typedef enum logic [1:0] {StIdle, StIssue, StLocked} state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic [2:0]    addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          cyc_q, cyc_d;
  logic          locked_q, locked_d;
  logic          lock_port_q, lock_port_d;
  logic          timeout_fire;

  // Round-robin pick: lowest valid index at or above rr_ptr, else lowest valid overall.
  logic          hi_found;
  logic [GW-1:0] first_all, first_hi, pick;

  always_comb begin
    hi_found  = 1'b0;
    first_all = '0;
    first_hi  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        first_all = GW'(i);
        if (i >= int'(rr_ptr_q)) begin
          hi_found = 1'b1;
          first_hi = GW'(i);
        end
      end
    end
    pick = hi_found ? first_hi : first_all;
  end

  // While locked only the lock owner is looked at.
  logic [GW-1:0] src;
  logic          src_valid;
  logic [2:0]    src_addr;
  logic [7:0]    src_data;

  always_comb begin
    src       = (state_q == StLocked) ? grant_q : pick;
    src_valid = 1'b0;
    src_addr  = '0;
    src_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (GW'(i) == src) begin
        src_valid = bus.req_valid[i];
        src_addr  = bus.req_addr[3*i +: 3];
        src_data  = bus.req_data[8*i +: 8];
      end
    end
  end

  logic [GW-1:0] rr_next;
  logic          is_addr, is_data;

  assign rr_next = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
  assign is_addr = ~addr_q[2] & ~addr_q[0];
  assign is_data = ~addr_q[2] & addr_q[0];

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cyc_d       = cyc_q;
    locked_d    = locked_q;
    lock_port_d = lock_port_q;
    unique case (state_q)
      StIdle, StLocked: begin
        if (src_valid) begin
          grant_d = src;
          addr_d  = src_addr;
          wdata_d = src_data;
          cyc_d   = 1'b1;
          state_d = StIssue;
        end else if (timeout_fire) begin
          state_d  = StIdle;
          locked_d = 1'b0;
          rr_ptr_d = rr_next;
        end
      end
      StIssue: begin
        if (bus.wb_ack) begin
          cyc_d = 1'b0;
          if (is_addr) begin
            state_d     = StLocked;
            locked_d    = 1'b1;
            lock_port_d = addr_q[1];
          end else if (locked_q) begin
            // Only the data write to the latched port closes the pair.
            if (is_data && (addr_q[1] == lock_port_q)) begin
              state_d  = StIdle;
              locked_d = 1'b0;
              rr_ptr_d = rr_next;
            end else begin
              state_d = StLocked;
            end
          end else begin
            state_d  = StIdle;
            rr_ptr_d = rr_next;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cyc_q       <= 1'b0;
      locked_q    <= 1'b0;
      lock_port_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cyc_q       <= cyc_d;
      locked_q    <= locked_d;
      lock_port_q <= lock_port_d;
    end
  end

`ifdef YM_ARB_LOCK_TIMEOUT_EN
  localparam int unsigned CW = $clog2(LOCK_TIMEOUT + 1);

  logic [CW-1:0] lock_ctr_q, lock_ctr_d;
  logic          timeout_q;

  // Counter is zero outside LOCKED, so every LOCKED entry starts from zero.
  always_comb begin
    lock_ctr_d   = lock_ctr_q;
    timeout_fire = 1'b0;
    if (state_q != StLocked) begin
      lock_ctr_d = '0;
    end else if (!src_valid) begin
      if (lock_ctr_q != CW'(LOCK_TIMEOUT)) begin
        lock_ctr_d = lock_ctr_q + 1'b1;
      end
      timeout_fire = (lock_ctr_d == CW'(LOCK_TIMEOUT));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_ctr_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      lock_ctr_q <= lock_ctr_d;
      timeout_q  <= timeout_fire;
    end
  end

  assign lock_timeout = timeout_q;
`else
  assign timeout_fire = 1'b0;
  assign lock_timeout = 1'b0;
`endif

  always_comb begin
    bus.req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_ready[i] = bus.wb_ack && (state_q == StIssue) && (grant_q == GW'(i));
    end
  end

  assign bus.wb_cyc   = cyc_q;
  assign bus.wb_we    = cyc_q;
  assign bus.wb_addr  = addr_q;
  assign bus.wb_wdata = wdata_q;
  assign grant_id     = grant_q;
  assign locked       = locked_q;

endmodule

// File: tb/tb_ym2610_cmd_arbiter.sv
// Directed self-checking bench for ym2610_cmd_arbiter with two requesters.
module tb_ym2610_cmd_arbiter;

  logic       clk;
  logic       reset;
  logic [0:0] grant_id;
  logic       locked;
  logic       lock_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  ym2610_cmd_arbiter_if #(.NUM_REQ(2)) bus ();

  ym2610_cmd_arbiter #(
    .NUM_REQ      (2),
    .LOCK_TIMEOUT (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .grant_id     (grant_id),
    .locked       (locked),
    .lock_timeout (lock_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [2:0] a, input logic [7:0] d);
    bus.req_valid[i]       = v;
    bus.req_addr[3*i +: 3] = a;
    bus.req_data[8*i +: 8] = d;
  endtask

  // One-cycle ack; the ready vector is checked while ack is high.
  task automatic ack_cycle(input string tag, input logic [1:0] exp_ready);
    bus.wb_ack = 1'b1;
    #1;
    check_eq(tag, 32'(bus.req_ready), 32'(exp_ready));
    @(posedge clk);
    #1;
    bus.wb_ack = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.wb_ack    = 1'b0;
    #22;
    check_eq("reset_bus", {bus.wb_cyc, bus.wb_we, bus.wb_addr, bus.wb_wdata, bus.req_ready}, 0);
    check_eq("reset_status", {grant_id, locked, lock_timeout}, 0);
    reset = 1'b0;
    tick();

    // Single ADDR write from req0
    set_req(0, 1'b1, 3'd0, 8'h28);
    check_eq("single_pre_cyc", 32'(bus.wb_cyc), 0);
    tick();
    check_eq("single_issue", {bus.wb_cyc, bus.wb_we, bus.wb_addr, bus.wb_wdata, grant_id},
             {1'b1, 1'b1, 3'd0, 8'h28, 1'b0});
    check_eq("single_ready_wait", 32'(bus.req_ready), 0);
    tick();
    check_eq("single_hold", {bus.wb_cyc, bus.wb_addr, bus.wb_wdata}, {1'b1, 3'd0, 8'h28});
    tick();
    ack_cycle("single_ready", 2'b01);
    set_req(0, 1'b0, 3'd0, 8'h00);
    check_eq("single_after", {bus.wb_cyc, bus.wb_we, locked}, 3'b001);

    // Atomic pair: req1 starves while req0 holds the lock
    set_req(1, 1'b1, 3'd2, 8'h77);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("pair_starve", {bus.wb_cyc, locked}, 2'b01);
    end
    set_req(0, 1'b1, 3'd1, 8'h55);
    tick();
    check_eq("pair_data_issue", {bus.wb_cyc, bus.wb_addr, bus.wb_wdata, grant_id},
             {1'b1, 3'd1, 8'h55, 1'b0});
    ack_cycle("pair_data_ready", 2'b01);
    set_req(0, 1'b0, 3'd0, 8'h00);
    check_eq("pair_unlocked", {bus.wb_cyc, locked}, 2'b00);
    tick();
    check_eq("pair_req1_grant", {bus.wb_cyc, bus.wb_addr, bus.wb_wdata, grant_id},
             {1'b1, 3'd2, 8'h77, 1'b1});
    ack_cycle("pair_req1_ready", 2'b10);
    check_eq("pair_req1_locked", 32'(locked), 1);
    set_req(1, 1'b1, 3'd3, 8'h11);
    tick();
    check_eq("pair_req1_data", {bus.wb_cyc, bus.wb_addr, bus.wb_wdata, grant_id},
             {1'b1, 3'd3, 8'h11, 1'b1});
    ack_cycle("pair_req1_dready", 2'b10);
    set_req(1, 1'b0, 3'd0, 8'h00);
    check_eq("pair_req1_unlock", 32'(locked), 0);

    // Round robin with both requesters holding CTRL writes
    set_req(0, 1'b1, 3'd4, 8'hA0);
    set_req(1, 1'b1, 3'd4, 8'hA1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq("rr_grant", {bus.wb_cyc, grant_id, bus.wb_wdata},
               {1'b1, 1'(k % 2), ((k % 2) == 0) ? 8'hA0 : 8'hA1});
      ack_cycle("rr_ready", ((k % 2) == 0) ? 2'b01 : 2'b10);
      check_eq("rr_gap", {bus.wb_cyc, locked}, 2'b00);
    end
    set_req(0, 1'b0, 3'd0, 8'h00);
    set_req(1, 1'b0, 3'd0, 8'h00);

    // Backpressure: ack withheld for 50 cycles
    set_req(0, 1'b1, 3'd5, 8'h3C);
    tick();
    for (int k = 0; k < 50; k++) begin
      check_eq("bp_hold", {bus.wb_cyc, bus.wb_we, bus.wb_addr, bus.wb_wdata, bus.req_ready},
               {1'b1, 1'b1, 3'd5, 8'h3C, 2'b00});
      tick();
    end
    ack_cycle("bp_ready", 2'b01);
    set_req(0, 1'b0, 3'd0, 8'h00);
    check_eq("bp_release", 32'(bus.wb_cyc), 0);

    // Lock left idle by req0 while req1 waits
    set_req(0, 1'b1, 3'd0, 8'h01);
    tick();
    check_eq("to_addr_issue", {bus.wb_cyc, grant_id}, 2'b10);
    ack_cycle("to_addr_ready", 2'b01);
    set_req(0, 1'b0, 3'd0, 8'h00);
    set_req(1, 1'b1, 3'd4, 8'h99);
`ifdef YM_ARB_LOCK_TIMEOUT_EN
    for (int k = 1; k < 16; k++) begin
      tick();
      check_eq("to_wait", {bus.wb_cyc, locked, lock_timeout}, 3'b010);
    end
    tick();
    check_eq("to_pulse", {bus.wb_cyc, locked, lock_timeout}, 3'b001);
    tick();
    check_eq("to_req1_grant", {bus.wb_cyc, grant_id, lock_timeout, bus.wb_wdata},
             {1'b1, 1'b1, 1'b0, 8'h99});
    ack_cycle("to_req1_ready", 2'b10);
    set_req(1, 1'b0, 3'd0, 8'h00);
`else
    for (int k = 0; k < 30; k++) begin
      tick();
      check_eq("nolock_to_hold", {bus.wb_cyc, locked, lock_timeout}, 3'b010);
    end
    set_req(0, 1'b1, 3'd1, 8'h02);
    tick();
    check_eq("nolock_to_data", {bus.wb_cyc, grant_id, bus.wb_addr}, {1'b1, 1'b0, 3'd1});
    ack_cycle("nolock_to_dready", 2'b01);
    set_req(0, 1'b0, 3'd0, 8'h00);
    check_eq("nolock_to_unlock", 32'(locked), 0);
    tick();
    check_eq("nolock_to_req1", {bus.wb_cyc, grant_id, bus.wb_addr, bus.wb_wdata},
             {1'b1, 1'b1, 3'd4, 8'h99});
    ack_cycle("nolock_to_r1ready", 2'b10);
    set_req(1, 1'b0, 3'd0, 8'h00);
`endif

    // Reset asserted mid-ISSUE
    set_req(1, 1'b1, 3'd0, 8'h42);
    tick();
    check_eq("rst_pre_issue", {bus.wb_cyc, grant_id}, 2'b11);
    #2;
    reset = 1'b1;
    #1;
    check_eq("rst_async", {bus.wb_cyc, bus.wb_we, locked, grant_id}, 0);
    set_req(0, 1'b1, 3'd4, 8'h5A);
    @(posedge clk);
    #3;
    check_eq("rst_held", 32'(bus.wb_cyc), 0);
    reset = 1'b0;
    tick();
    check_eq("rst_first_grant", {bus.wb_cyc, grant_id, bus.wb_addr, bus.wb_wdata},
             {1'b1, 1'b0, 3'd4, 8'h5A});
    ack_cycle("rst_ready", 2'b01);
    set_req(0, 1'b0, 3'd0, 8'h00);
    set_req(1, 1'b0, 3'd0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ym2610_cmd_arbiter.md
Name: ym2610_cmd_arbiter

Overview:
- Shares the single write-only Wishbone command port of the YM2610 controller between NUM_REQ hardware requesters, e.g. CPU bridge, VGM/music sequencer, SFX engine.
- Round-robin arbitration with atomic register-write locking: once a requester writes a register address (port A/B address latch), it keeps the grant until its matching data write completes. This prevents another requester's address write from corrupting the pair.
- Sits between requester logic and the controller's wb_* slave interface.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- LOCK_TIMEOUT, 1024, clk cycles a lock may idle before forced release (only with YM_ARB_LOCK_TIMEOUT_EN).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_addr  in  3*NUM_REQ  packed command address, requester i at [3i+2:3i].
- req_data  in  8*NUM_REQ  packed command data, requester i at [8i+7:8i].
- req_ready  out  NUM_REQ  command accepted, one-hot pulse.
- wb_addr  out  3  controller address (0-3 YM port A/B addr/data, 4-7 reset control).
- wb_wdata  out  8  controller write data.
- wb_we  out  1  write enable.
- wb_cyc  out  1  cycle request.
- wb_ack  in  1  controller acknowledge; withheld while controller FIFO full.
- grant_id  out  GW = max(1, clog2(NUM_REQ))  current/last granted requester.
- locked  out  1  address/data pair lock held.
- lock_timeout  out  1  one-cycle pulse on forced lock release.

Behaviour:
- Reset, asynchronous, all outputs: wb_cyc=0, wb_we=0, wb_addr=0, wb_wdata=0, req_ready=0, grant_id=0, locked=0, lock_timeout=0, rr_ptr=0, state=IDLE. A reset mid-cycle drops wb_cyc immediately; the in-flight command is lost.
- Requester contract:
  - Command transfers on req_valid[i] && req_ready[i].
  - addr/data must hold stable while valid.
  - req_ready[i] = wb_ack && state==ISSUE && grant_id==i (combinational).
- Command classes:
  - ADDR = addr[2]==0 && addr[0]==0, port = addr[1].
  - DATA = addr[2]==0 && addr[0]==1.
  - CTRL = addr[2]==1.
- State machine:
  - IDLE:
    - If any req_valid, select first valid index scanning from rr_ptr upward with wrap.
    - Register grant_id, wb_addr, wb_wdata; set wb_cyc=1, wb_we=1; go to ISSUE.
    - Latency req_valid to wb_cyc = 1 cycle.
  - ISSUE:
    - Hold wb_cyc/wb_addr/wb_wdata until wb_ack. Unbounded backpressure is allowed.
    - On ack: wb_cyc=0, wb_we=0 next cycle (guaranteed ≥1 idle cycle between cycles, matching the controller's ack toggle).
    - Then: ADDR → LOCKED, locked=1, lock_port=addr[1].
    - DATA on lock_port while locked → IDLE, locked=0, rr_ptr=grant_id+1 mod NUM_REQ.
    - DATA/CTRL while unlocked → IDLE, rr_ptr advanced.
    - CTRL while locked → LOCKED.
    - DATA to the other port while locked → LOCKED, lock kept.
  - LOCKED:
    - Only req_valid[grant_id] considered; others starve.
    - When valid, issue its command as in IDLE → ISSUE.
    - A further ADDR updates lock_port.
- Simultaneous requests: exactly one granted per IDLE decision; ties are broken by rr_ptr.
- NUM_REQ=1: rr_ptr constant 0; locking still applies.
- The block never reads wb_rdata; wb_we is never 0 while wb_cyc=1.

Optional Feature:
YM_ARB_LOCK_TIMEOUT_EN
- Defined: lock_ctr resets on LOCKED entry and counts cycles in LOCKED with req_valid[grant_id]==0. At LOCK_TIMEOUT it forces IDLE, locked=0, rr_ptr advanced, and lock_timeout pulses for 1 cycle. The counter is clog2(LOCK_TIMEOUT+1) bits and saturates.
- Undefined: the lock is held indefinitely; lock_timeout tied 0; no counter logic.

Test Plan:
- Single write: req0 addr=0 data=0x28, wb_ack 2 cycles after cyc → wb_cyc 1 cycle after valid, wb_addr=0, wb_wdata=0x28, req_ready[0] pulses with ack, locked=1.
- Round-robin: req0/req1 both valid with CTRL addr=4, held → grants 0,1,0,1; each req_ready one-hot; wb_cyc low ≥1 cycle between grants.
- Atomic pair: req0 addr=0 data=0x10 accepted, then req1 valid addr=2 → req1 waits; req0 addr=1 data=0x55 issued next; only after its ack does req1 get the grant.
- Backpressure: wb_ack held low 50 cycles → wb_addr/wb_wdata/wb_cyc stable, req_ready=0 throughout; single ready on ack.
- Timeout (macro on, LOCK_TIMEOUT=16): req0 ADDR then idle, req1 valid → lock_timeout pulse 16 cycles after LOCKED entry, req1 granted next IDLE; macro off → req1 never granted.
- Reset mid-ISSUE: assert reset while wb_cyc=1 → wb_cyc=0 asynchronously, locked=0, grant_id=0; after release, first valid requester from index 0 granted.
